// File: rtl/debounce_sync.sv
// debounce_sync: multi-flop synchronizer feeding a stability-qualifying FSM.
// The raw level must hold for STABLE_CYCLES synchronized cycles before db_out
// follows it; shorter excursions are rejected as bounce.
// Optional feature macro: DEBOUNCE_EDGE_EN. When defined, rise_pulse and
// fall_pulse strobe for one cycle on each db_out transition. When undefined,
// both ports are tied to 0.

module debounce_sync #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned STABLE_CYCLES = 1000,
    parameter int unsigned CNT_W         = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic db_out,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        STABLE_LO,
        CHK_HI,
        STABLE_HI,
        CHK_LO
    } state_t;

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    state_t                 state;
    logic [CNT_W-1:0]       cnt;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // Synchronizer chain: btn_in enters at bit 0, the oldest stage drives the FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], btn_in};
        end
    end

    // Qualification FSM. db_out and busy are registered alongside the state so
    // they reflect the state entered at this edge. The counter only advances
    // while checking and is cleared on every exit, so it stays within
    // 0..STABLE_CYCLES-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= STABLE_LO;
            cnt    <= '0;
            db_out <= 1'b0;
            busy   <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`endif
        end else begin
`ifdef DEBOUNCE_EDGE_EN
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
`endif
            case (state)
                STABLE_LO: begin
                    db_out <= 1'b0;
                    if (sync_q) begin
                        state <= CHK_HI;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end

                CHK_HI: begin
                    if (!sync_q) begin
                        state  <= STABLE_LO;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        db_out <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_HI;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        db_out <= 1'b1;
`ifdef DEBOUNCE_EDGE_EN
                        rise_pulse <= 1'b1;
`endif
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        busy   <= 1'b1;
                        db_out <= 1'b0;
                    end
                end

                STABLE_HI: begin
                    db_out <= 1'b1;
                    if (!sync_q) begin
                        state <= CHK_LO;
                        cnt   <= CNT_ONE;
                        busy  <= 1'b1;
                    end else begin
                        cnt  <= '0;
                        busy <= 1'b0;
                    end
                end

                CHK_LO: begin
                    if (sync_q) begin
                        state  <= STABLE_HI;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        db_out <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        state  <= STABLE_LO;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        db_out <= 1'b0;
`ifdef DEBOUNCE_EDGE_EN
                        fall_pulse <= 1'b1;
`endif
                    end else begin
                        cnt    <= cnt + CNT_ONE;
                        busy   <= 1'b1;
                        db_out <= 1'b1;
                    end
                end

                default: begin
                    state  <= STABLE_LO;
                    cnt    <= '0;
                    busy   <= 1'b0;
                    db_out <= 1'b0;
                end
            endcase
        end
    end

`ifndef DEBOUNCE_EDGE_EN
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_sync.sv
// Directed bench for debounce_sync with SYNC_STAGES=2, STABLE_CYCLES=4.
// Outputs are checked as the vector {db_out, busy, rise_pulse, fall_pulse},
// sampled 1 time unit after each rising edge. Pulse expectations follow
// whether DEBOUNCE_EDGE_EN is defined for the build.

module tb_debounce_sync;

`ifdef DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic clk;
    logic rst;
    logic btn_in;
    logic db_out;
    logic rise_pulse;
    logic fall_pulse;
    logic busy;

    int n_cmp = 0;
    int n_bad = 0;

    debounce_sync #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(4),
        .CNT_W        (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_in    (btn_in),
        .db_out    (db_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset holds everything low even with btn_in high; release qualifies a rise.
    task automatic test_reset();
        logic [3:0] obs, exp;
        btn_in = 1'b1;
        rst    = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = 4'b0000;
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_hold i=%0d got %b want %b", i, obs, exp);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {(i >= 5), (i >= 2 && i <= 4), (EDGE_EN && i == 5), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL reset_exit_rise i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // From db_out=1: low for 3 sampled edges, bounce back exactly at count 3.
    task automatic test_glitch_lo_reject();
        logic [3:0] obs, exp;
        for (int i = 0; i < 10; i++) begin
            btn_in = (i >= 3);
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {1'b1, (i >= 2 && i <= 4), 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL glitch_lo_reject i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_clean_fall();
        logic [3:0] obs, exp;
        btn_in = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {(i < 5), (i >= 2 && i <= 4), 1'b0, (EDGE_EN && i == 5)};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL clean_fall i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Step sampled at relative edge 0: busy at 2..4, db_out and rise at 5.
    task automatic test_clean_rise();
        logic [3:0] obs, exp;
        btn_in = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {(i >= 5), (i >= 2 && i <= 4), (EDGE_EN && i == 5), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL clean_rise i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // From db_out=0: high for 3 sampled edges, drops exactly at count 3.
    task automatic test_glitch_hi_reject();
        logic [3:0] obs, exp;
        for (int i = 0; i < 10; i++) begin
            btn_in = (i < 3);
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {1'b0, (i >= 2 && i <= 4), 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL glitch_hi_reject i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // btn_in 1,1,0,0,1,1,0,0 then 0: two short qualifications, both abandoned.
    task automatic test_toggle();
        logic [3:0] obs, exp;
        for (int i = 0; i < 12; i++) begin
            btn_in = (i < 8) && ((i / 2) % 2 == 0);
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {1'b0, (i == 2 || i == 3 || i == 6 || i == 7), 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL toggle_bounce i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    // Reset while CHK_HI holds count 2; requalification must take the full latency.
    task automatic test_reset_mid_qual();
        logic [3:0] obs, exp;
        btn_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {1'b0, (i >= 2), 1'b0, 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL mid_rst_pre i=%0d got %b want %b", i, obs, exp);
            end
        end
        #2;
        rst = 1'b1;
        #1;
        obs = {db_out, busy, rise_pulse, fall_pulse};
        exp = 4'b0000;
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_rst_async got %b want %b", obs, exp);
        end
        tick();
        obs = {db_out, busy, rise_pulse, fall_pulse};
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL mid_rst_hold got %b want %b", obs, exp);
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            obs = {db_out, busy, rise_pulse, fall_pulse};
            exp = {(i >= 5), (i >= 2 && i <= 4), (EDGE_EN && i == 5), 1'b0};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL mid_rst_requal i=%0d got %b want %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        rst    = 1'b1;
        btn_in = 1'b0;
        test_reset();
        test_glitch_lo_reject();
        test_clean_fall();
        test_clean_rise();
        test_clean_fall();
        test_glitch_hi_reject();
        test_toggle();
        test_reset_mid_qual();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/debounce_sync.md
DEBOUNCE_SYNC -- requirements
Module: debounce_sync

Interface
REQ-001 Parameter SYNC_STAGES, default 2: number of synchronizer flops on the raw input; legal range 2..4.
REQ-002 Parameter STABLE_CYCLES, default 1000: consecutive stable synchronized cycles required before the output changes; legal range 2..65535.
REQ-003 Parameter CNT_W, default 16: stability counter width; SHALL satisfy 2^CNT_W > STABLE_CYCLES.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous and active-high.
REQ-006 Port btn_in, input, 1: raw asynchronous level from a switch or pin; bouncy, no timing relation to clk.
REQ-007 Port db_out, output, 1: debounced level; the d_in source for the downstream D flipflop stage.
REQ-008 Port rise_pulse, output, 1: one-cycle pulse when db_out goes 0->1.
REQ-009 Port fall_pulse, output, 1: one-cycle pulse when db_out goes 1->0.
REQ-010 Port busy, output, 1: high while a candidate transition is being qualified.

Function
REQ-011 btn_in SHALL pass through a SYNC_STAGES-deep flop chain; only the last stage (sync_q) SHALL feed the logic below.
REQ-012 FSM states SHALL be STABLE_LO, CHK_HI, STABLE_HI, CHK_LO; db_out SHALL be 1 in STABLE_HI and CHK_LO, 0 otherwise, registered.
REQ-013 STABLE_LO: sync_q=1 -> CHK_HI with counter=1; otherwise stay, counter=0.
REQ-014 CHK_HI: sync_q=0 -> STABLE_LO, counter=0 (bounce rejected); sync_q=1 and counter=STABLE_CYCLES-1 -> STABLE_HI, counter=0; else counter+1.
REQ-015 STABLE_HI / CHK_LO SHALL mirror REQ-013/014 with levels inverted.
REQ-016 Latency: a clean btn_in step sampled at edge k SHALL change db_out at edge k+SYNC_STAGES+STABLE_CYCLES-1; any glitch shorter than STABLE_CYCLES cycles at sync_q SHALL leave db_out unchanged.
REQ-017 Counter SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap; the counter is don't-care only in STABLE_ states where it is held 0.
REQ-018 busy SHALL equal 1 exactly in CHK_HI and CHK_LO.
REQ-019 rise_pulse/fall_pulse SHALL assert in the same cycle db_out first shows its new value, for exactly one cycle; never both high together.
REQ-020 A bounce arriving on the exact cycle the counter reaches STABLE_CYCLES-1 SHALL reject the transition (sync_q value at that edge decides).

Reset
REQ-021 rst=1 SHALL immediately force: all sync flops 0, state STABLE_LO, counter 0, db_out 0, rise_pulse 0, fall_pulse 0, busy 0.
REQ-022 Reset asserted mid-qualification SHALL abandon it; no pulse SHALL be emitted on reset entry or exit.
REQ-023 After rst deassert with btn_in held 1, the block SHALL qualify it as a normal rise (rise_pulse after full latency).

Configuration
REQ-024 Macro DEBOUNCE_EDGE_EN: when defined, rise_pulse/fall_pulse SHALL behave per REQ-019.
REQ-025 Without DEBOUNCE_EDGE_EN, rise_pulse and fall_pulse SHALL remain ports tied constant 0, with no edge-detect logic; all other behaviour identical.

Verification (bench: SYNC_STAGES=2, STABLE_CYCLES=4, DEBOUNCE_EDGE_EN defined)
REQ-026 rst=1 with btn_in=1, then release -> db_out=0 and all outputs 0 during reset; db_out=1 and rise_pulse=1 for one cycle 5 edges after the first sampling edge post-release.
REQ-027 Clean 0->1 step sampled at edge 10 -> busy high edges 12-14, db_out=1 and rise_pulse=1 at edge 15, rise_pulse=0 at edge 16.
REQ-028 btn_in toggles 1,0,1,0 every 2 cycles then holds 0 -> db_out stays 0, no pulses, busy returns 0.
REQ-029 From db_out=1, btn_in low for 3 cycles then high -> db_out stays 1, fall_pulse never asserts.
REQ-030 rst pulsed during CHK_HI with counter=2 -> db_out=0, busy=0 immediately, no rise_pulse; requalification restarts from counter 0.
REQ-031 Rebuild without DEBOUNCE_EDGE_EN, repeat REQ-027 -> db_out identical, rise_pulse and fall_pulse constantly 0.
